// File: rtl/cnn_cmd_sched_if.sv
// Signal bundle between the host command stream / cnn core taps and the command sequencer.
// Handshakes: a command transfers on a rising clk edge where cmd_val & cmd_rdy are both high; a result beat
// counts on an edge where rlt_val & rlt_rdy are both high; cfg_valid and done are one-cycle strobes with no back-pressure.
interface cnn_cmd_sched_if #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int CNT_WIDTH  = 32,
  parameter int TAG_WIDTH  = 8
);
  logic [CFG_DWIDTH+CFG_AWIDTH+1:0] cmd_bus;
  logic                             cmd_val;
  logic                             cmd_rdy;
  logic [CFG_DWIDTH-1:0]            cfg_data;
  logic [CFG_AWIDTH-1:0]            cfg_addr;
  logic                             cfg_valid;
  logic                             rlt_val;
  logic                             rlt_rdy;
  logic                             busy;
  logic                             done;
  logic [TAG_WIDTH-1:0]             done_tag;
  logic                             err;
  logic [1:0]                       dbg_state;
  logic [CNT_WIDTH-1:0]             dbg_beat_cnt;

  modport slave (
    input  cmd_bus, cmd_val, rlt_val, rlt_rdy,
    output cmd_rdy, cfg_data, cfg_addr, cfg_valid, busy, done, done_tag, err,
           dbg_state, dbg_beat_cnt
  );

  modport master (
    output cmd_bus, cmd_val, rlt_val, rlt_rdy,
    input  cmd_rdy, cfg_data, cfg_addr, cfg_valid, busy, done, done_tag, err,
           dbg_state, dbg_beat_cnt
  );
endinterface

// File: rtl/cnn_cmd_sched.sv
// Command sequencer: replays host commands as cnn cfg writes, paces layers on result beats
// and reports layer completion through done/done_tag.
module cnn_cmd_sched #(
  parameter int CFG_DWIDTH = 32,
  parameter int CFG_AWIDTH = 5,
  parameter int CNT_WIDTH  = 32,
  parameter int TAG_WIDTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  cnn_cmd_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_WAIT  = 2'b01;
  localparam logic [1:0] OP_DONE  = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_next, tgt_q;
  logic [CFG_DWIDTH-1:0] cfg_data_q;
  logic [CFG_AWIDTH-1:0] cfg_addr_q;
  logic                  cfg_valid_q, done_q, err_q;
  logic [TAG_WIDTH-1:0]  done_tag_q;

  logic [1:0]            op;
  logic [CFG_AWIDTH-1:0] addr;
  logic [CFG_DWIDTH-1:0] operand;
  logic                  cmd_rdy, accept, beat, sat, wait_hit;

  assign op      = bus.cmd_bus[CFG_DWIDTH+CFG_AWIDTH+1 -: 2];
  assign addr    = bus.cmd_bus[CFG_DWIDTH+CFG_AWIDTH-1 : CFG_DWIDTH];
  assign operand = bus.cmd_bus[CFG_DWIDTH-1:0];

  // Gated by rst_n so the host never sees ready while the block is held in reset.
  assign cmd_rdy = (state_q == S_IDLE) && rst_n;
  assign accept  = bus.cmd_val && cmd_rdy;

  assign beat          = bus.rlt_val && bus.rlt_rdy;
  assign sat           = &beat_cnt_q;
  assign beat_cnt_next = (beat && !sat) ? beat_cnt_q + 1'b1 : beat_cnt_q;
  assign wait_hit      = (beat_cnt_next >= tgt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (op == OP_WRITE)     state_d = S_WRITE;
          else if (op == OP_WAIT) state_d = S_WAIT;
        end
      end
      S_WRITE: state_d = S_IDLE;
      S_WAIT:  if (wait_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Surplus beats beyond the target are carried into the next WAIT rather than dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q <= '0;
      tgt_q      <= '0;
    end else begin
      if (state_q == S_WAIT && wait_hit) beat_cnt_q <= beat_cnt_next - tgt_q;
      else                               beat_cnt_q <= beat_cnt_next;
      if (accept && op == OP_WAIT) tgt_q <= CNT_WIDTH'(operand);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      done_q      <= 1'b0;
      done_tag_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cfg_valid_q <= accept && (op == OP_WRITE);
      if (accept && op == OP_WRITE) begin
        cfg_addr_q <= addr;
        cfg_data_q <= operand;
      end
      done_q <= accept && (op == OP_DONE);
      if (accept && op == OP_DONE) done_tag_q <= operand[TAG_WIDTH-1:0];
      if ((accept && op == OP_RSVD) || (beat && sat)) err_q <= 1'b1;
    end
  end

  assign bus.cmd_rdy      = cmd_rdy;
  assign bus.cfg_valid    = cfg_valid_q;
  assign bus.cfg_addr     = cfg_addr_q;
  assign bus.cfg_data     = cfg_data_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = done_q;
  assign bus.done_tag     = done_tag_q;
  assign bus.err          = err_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_cnn_cmd_sched.sv
// Directed bench for cnn_cmd_sched: reset, cfg writes, WAIT pacing with carry-over,
// DONE/reserved ops and a full layer command list.
module tb_cnn_cmd_sched;

  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_WT = 2'b01;
  localparam logic [1:0] OP_DN = 2'b10;
  localparam logic [1:0] OP_RS = 2'b11;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [36:0] exp_q[$];

  cnn_cmd_sched_if bif ();

  cnn_cmd_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [38:0] make_cmd(input logic [1:0] op, input logic [4:0] addr,
                                           input logic [31:0] operand);
    return {op, addr, operand};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: waits (bounded) for ready, presents one command for one edge
  task automatic send_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [31:0] operand);
    int guard;
    guard = 0;
    while (!bif.cmd_rdy && guard < 50) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (bif.cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: cmd_rdy got %b exp 1", bif.cmd_rdy);
    end
    bif.cmd_bus = make_cmd(op, addr, operand);
    bif.cmd_val = 1'b1;
    tick();
    bif.cmd_val = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({bif.cmd_rdy, bif.busy, bif.done, bif.err, bif.cfg_valid} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_flags: got %b exp 00000",
               {bif.cmd_rdy, bif.busy, bif.done, bif.err, bif.cfg_valid});
    end
    n_cmp++;
    if ({bif.cfg_addr, bif.cfg_data, bif.done_tag, bif.dbg_beat_cnt} !== '0) begin
      n_fail++;
      $display("FAIL rst_regs: addr %h data %h tag %h cnt %0d exp all 0",
               bif.cfg_addr, bif.cfg_data, bif.done_tag, bif.dbg_beat_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bif.cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rdy: got %b exp 1", bif.cmd_rdy);
    end
    // abort a WAIT with three beats counted
    send_cmd(OP_WT, 5'd0, 32'd10);
    bif.rlt_val = 1'b1;
    bif.rlt_rdy = 1'b1;
    repeat (3) tick();
    bif.rlt_val = 1'b0;
    bif.rlt_rdy = 1'b0;
    n_cmp++;
    if (bif.busy !== 1'b1 || bif.dbg_beat_cnt !== 32'd3) begin
      n_fail++;
      $display("FAIL mid_wait: busy %b cnt %0d exp 1 3", bif.busy, bif.dbg_beat_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bif.cmd_rdy, bif.busy, bif.done, bif.err, bif.cfg_valid} !== 5'b0
        || bif.dbg_beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL async_rst: flags %b cnt %0d exp 0 0",
               {bif.cmd_rdy, bif.busy, bif.done, bif.err, bif.cfg_valid}, bif.dbg_beat_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (bif.busy !== 1'b0 || bif.dbg_beat_cnt !== '0 || bif.cmd_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst: busy %b cnt %0d rdy %b exp 0 0 1",
               bif.busy, bif.dbg_beat_cnt, bif.cmd_rdy);
    end
  endtask

  task automatic test_write();
    n_cmp++;
    if (bif.cfg_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_pre: cfg_valid got %b exp 0", bif.cfg_valid);
    end
    send_cmd(OP_WR, 5'd5, 32'hDEADBEEF);
    n_cmp++;
    if (bif.cfg_valid !== 1'b1 || bif.cfg_addr !== 5'd5 || bif.cfg_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_strobe: valid %b addr %0d data %h exp 1 5 deadbeef",
               bif.cfg_valid, bif.cfg_addr, bif.cfg_data);
    end
    n_cmp++;
    if (bif.busy !== 1'b1 || bif.cmd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_busy: busy %b rdy %b exp 1 0", bif.busy, bif.cmd_rdy);
    end
    tick();
    n_cmp++;
    if (bif.cfg_valid !== 1'b0 || bif.cfg_addr !== 5'd5 || bif.cfg_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_hold: valid %b addr %0d data %h exp 0 5 deadbeef",
               bif.cfg_valid, bif.cfg_addr, bif.cfg_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] wl[4];
    logic [36:0] exp;
    logic        took;
    int          idx;
    wl[0] = {5'd1, 32'h11111111};
    wl[1] = {5'd2, 32'h22222222};
    wl[2] = {5'd3, 32'h33333333};
    wl[3] = {5'd4, 32'h44444444};
    idx = 0;
    bif.cmd_val = 1'b1;
    bif.cmd_bus = make_cmd(OP_WR, wl[0][36:32], wl[0][31:0]);
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (bif.cmd_rdy !== ((c % 2) == 0)) begin
        n_fail++;
        $display("FAIL b2b_rdy c%0d: got %b exp %b", c, bif.cmd_rdy, ((c % 2) == 0));
      end
      took = bif.cmd_rdy && bif.cmd_val;
      if (took) exp_q.push_back(wl[idx]);
      tick();
      if (took) begin
        idx++;
        if (idx < 4) bif.cmd_bus = make_cmd(OP_WR, wl[idx][36:32], wl[idx][31:0]);
        else         bif.cmd_val = 1'b0;
      end
      n_cmp++;
      if (bif.cfg_valid !== took) begin
        n_fail++;
        $display("FAIL b2b_strobe c%0d: got %b exp %b", c, bif.cfg_valid, took);
      end
      if (took) begin
        exp = exp_q.pop_front();
        n_cmp++;
        if ({bif.cfg_addr, bif.cfg_data} !== exp) begin
          n_fail++;
          $display("FAIL b2b_data c%0d: got %h exp %h", c, {bif.cfg_addr, bif.cfg_data}, exp);
        end
      end
    end
    n_cmp++;
    if (idx != 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d exp 4", idx);
    end
  endtask

  task automatic test_wait_gapped();
    logic [1:0] pat[8];
    int hs;
    pat = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10, 2'b11};
    hs = 0;
    send_cmd(OP_WT, 5'd0, 32'd4);
    for (int i = 0; i < 8; i++) begin
      bif.rlt_val = pat[i][1];
      bif.rlt_rdy = pat[i][0];
      tick();
      if (pat[i] == 2'b11) hs++;
      n_cmp++;
      if (hs < 4) begin
        if (bif.busy !== 1'b1 || bif.dbg_beat_cnt !== 32'(hs)) begin
          n_fail++;
          $display("FAIL gap_wait i%0d: busy %b cnt %0d exp 1 %0d", i, bif.busy, bif.dbg_beat_cnt, hs);
        end
      end else begin
        if (bif.busy !== 1'b0 || bif.dbg_beat_cnt !== '0) begin
          n_fail++;
          $display("FAIL gap_exit i%0d: busy %b cnt %0d exp 0 0", i, bif.busy, bif.dbg_beat_cnt);
        end
      end
    end
    bif.rlt_val = 1'b0;
    bif.rlt_rdy = 1'b0;
  endtask

  task automatic test_carry_over();
    bif.rlt_val = 1'b1;
    bif.rlt_rdy = 1'b1;
    repeat (6) tick();
    bif.rlt_val = 1'b0;
    bif.rlt_rdy = 1'b0;
    n_cmp++;
    if (bif.dbg_beat_cnt !== 32'd6 || bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_beats: cnt %0d busy %b exp 6 0", bif.dbg_beat_cnt, bif.busy);
    end
    send_cmd(OP_WT, 5'd0, 32'd4);
    n_cmp++;
    if (bif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL carry1_enter: busy %b exp 1", bif.busy);
    end
    tick();
    n_cmp++;
    if (bif.busy !== 1'b0 || bif.dbg_beat_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL carry1_exit: busy %b cnt %0d exp 0 2", bif.busy, bif.dbg_beat_cnt);
    end
    send_cmd(OP_WT, 5'd0, 32'd2);
    tick();
    n_cmp++;
    if (bif.busy !== 1'b0 || bif.dbg_beat_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL carry2_exit: busy %b cnt %0d exp 0 0", bif.busy, bif.dbg_beat_cnt);
    end
  endtask

  task automatic test_boundaries();
    send_cmd(OP_WT, 5'd0, 32'd0);
    n_cmp++;
    if (bif.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wait0_enter: busy %b exp 1", bif.busy);
    end
    tick();
    n_cmp++;
    if (bif.busy !== 1'b0 || bif.dbg_beat_cnt !== '0) begin
      n_fail++;
      $display("FAIL wait0_exit: busy %b cnt %0d exp 0 0", bif.busy, bif.dbg_beat_cnt);
    end
    send_cmd(OP_DN, 5'd0, 32'h0000005A);
    n_cmp++;
    if (bif.done !== 1'b1 || bif.done_tag !== 8'h5A || bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done %b tag %h busy %b exp 1 5a 0", bif.done, bif.done_tag, bif.busy);
    end
    n_cmp++;
    if (bif.err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_pre: got %b exp 0", bif.err);
    end
    send_cmd(OP_RS, 5'd0, 32'd0);
    n_cmp++;
    if (bif.done !== 1'b0 || bif.done_tag !== 8'h5A || bif.err !== 1'b1 || bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rsvd: done %b tag %h err %b busy %b exp 0 5a 1 0",
               bif.done, bif.done_tag, bif.err, bif.busy);
    end
    repeat (3) tick();
    n_cmp++;
    if (bif.err !== 1'b1 || bif.cmd_rdy !== 1'b1 || bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_sticky: err %b rdy %b busy %b exp 1 1 0", bif.err, bif.cmd_rdy, bif.busy);
    end
  endtask

  task automatic test_layer();
    logic [31:0] d;
    logic        b;
    int          hs;
    for (int i = 0; i < 8; i++) begin
      d = 32'h1000_0000 + 32'(i) * 32'h111;
      send_cmd(OP_WR, 5'(i + 8), d);
      n_cmp++;
      if (bif.cfg_valid !== 1'b1 || bif.cfg_addr !== 5'(i + 8) || bif.cfg_data !== d) begin
        n_fail++;
        $display("FAIL layer_wr%0d: valid %b addr %0d data %h exp 1 %0d %h",
                 i, bif.cfg_valid, bif.cfg_addr, bif.cfg_data, i + 8, d);
      end
    end
    send_cmd(OP_WT, 5'd0, 32'd16);
    // DONE is presented while WAIT blocks; it must only be taken once the WAIT retires
    bif.cmd_bus = make_cmd(OP_DN, 5'd0, 32'd1);
    bif.cmd_val = 1'b1;
    hs = 0;
    for (int c = 0; c < 40; c++) begin
      b = ((c % 3) != 2);
      bif.rlt_val = b;
      bif.rlt_rdy = b;
      tick();
      if (b) hs++;
      n_cmp++;
      if (hs < 16) begin
        if (bif.busy !== 1'b1 || bif.done !== 1'b0) begin
          n_fail++;
          $display("FAIL layer_wait c%0d: busy %b done %b exp 1 0", c, bif.busy, bif.done);
        end
      end else begin
        if (bif.busy !== 1'b0 || bif.done !== 1'b0 || bif.cmd_rdy !== 1'b1) begin
          n_fail++;
          $display("FAIL layer_exit: busy %b done %b rdy %b exp 0 0 1", bif.busy, bif.done, bif.cmd_rdy);
        end
        break;
      end
    end
    bif.rlt_val = 1'b0;
    bif.rlt_rdy = 1'b0;
    n_cmp++;
    if (hs != 16) begin
      n_fail++;
      $display("FAIL layer_beats: got %0d exp 16", hs);
    end
    tick();
    bif.cmd_val = 1'b0;
    n_cmp++;
    if (bif.done !== 1'b1 || bif.done_tag !== 8'h01) begin
      n_fail++;
      $display("FAIL layer_done: done %b tag %h exp 1 01", bif.done, bif.done_tag);
    end
    tick();
    n_cmp++;
    if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL layer_after: done %b busy %b exp 0 0", bif.done, bif.busy);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bif.cmd_bus = '0;
    bif.cmd_val = 1'b0;
    bif.rlt_val = 1'b0;
    bif.rlt_rdy = 1'b0;
    test_reset();
    test_write();
    test_back_to_back();
    test_wait_gapped();
    test_carry_over();
    test_boundaries();
    test_layer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
